// File: rtl/dm_store_buffer.sv
// Write-posting store queue in front of the data RAM; steers the shared RAM port between loads and drains.
// Optional feature: define STORE_BUF_BYPASS_EN to send a store straight to the RAM when the queue is empty and no load is active.
module dm_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_wdata,
  input  logic [31:0] st_pc,
  output logic        st_full,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        sb_empty,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  output logic [31:0] ram_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;

  logic [29:0] addr_mem  [DEPTH];
  logic [3:0]  be_mem    [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [DEPTH-1:0] match;
  logic             drain;
  logic             bypass;
  logic             push;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // An entry is live when its distance from head is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] offset;
      assign offset    = PTR_W'(gi) - head_reg;
      assign match[gi] = ({1'b0, offset} < count_reg) && (addr_mem[gi] == ld_addr[31:2]);
    end
  endgenerate

  assign sb_empty  = (count_reg == '0);
  assign st_full   = (count_reg == (PTR_W+1)'(DEPTH));
  assign ld_hazard = ld_req && (|match);
  assign drain     = !sb_empty && (!ld_req || ld_hazard);

`ifdef STORE_BUF_BYPASS_EN
  assign bypass = st_req && sb_empty && !ld_req;
`else
  assign bypass = 1'b0;
`endif

  assign push = st_req && !st_full && !bypass;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ld_addr;
    ram_be    = 4'b0000;
    ram_wdata = 32'h0;
    ram_pc    = 32'h0;
    if (drain) begin
      ram_we    = 1'b1;
      ram_addr  = {addr_mem[head_reg], 2'b00};
      ram_be    = be_mem[head_reg];
      ram_wdata = wdata_mem[head_reg];
      ram_pc    = pc_mem[head_reg];
    end else if (bypass) begin
      ram_we    = 1'b1;
      ram_addr  = {st_addr[31:2], 2'b00};
      ram_be    = st_be;
      ram_wdata = st_wdata;
      ram_pc    = st_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push)
        tail_reg <= tail_reg + 1'b1;
      if (drain)
        head_reg <= head_reg + 1'b1;
      case ({push, drain})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage needs no reset: liveness is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg]  <= st_addr[31:2];
      be_mem[tail_reg]    <= st_be;
      wdata_mem[tail_reg] <= st_wdata;
      pc_mem[tail_reg]    <= st_pc;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Randomized scoreboard bench for dm_store_buffer against a queue-based reference model.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = '0;
  logic [3:0]  st_be = '0;
  logic [31:0] st_wdata = '0;
  logic [31:0] st_pc = '0;
  logic        st_full;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hazard;
  logic        sb_empty;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_pc;

  always #5 clk = ~clk;

  dm_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_req(st_req), .st_addr(st_addr), .st_be(st_be), .st_wdata(st_wdata), .st_pc(st_pc),
    .st_full(st_full), .ld_req(ld_req), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .sb_empty(sb_empty), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_pc(ram_pc)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_t;

  typedef struct {
    logic        hz;
    logic        full;
    logic        empty;
    logic        we;
    logic [31:0] addr;
  } st_t;

  wr_t model_q[$];
  wr_t exp_wr[$];
  st_t exp_st[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic [3:0] be_tab [7] = '{4'hF, 4'h3, 4'hC, 4'h8, 4'h4, 4'h2, 4'h1};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: pending stores are a plain queue; outputs follow the arbitration rules directly.
  task automatic cycle(input logic sr, input logic [31:0] sa, input logic [3:0] sb,
                       input logic [31:0] sd, input logic [31:0] sp,
                       input logic lr, input logic [31:0] la, output logic acc);
    st_t  s;
    wr_t  w;
    logic hz, full, empty, byp, drn;
    @(posedge clk); #1;
    st_req = sr; st_addr = sa; st_be = sb; st_wdata = sd; st_pc = sp;
    ld_req = lr; ld_addr = la;
    hz = 1'b0;
    foreach (model_q[i]) if (lr && model_q[i].addr[31:2] == la[31:2]) hz = 1'b1;
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    byp   = 1'b0;
`ifdef STORE_BUF_BYPASS_EN
    byp = sr && empty && !lr;
`endif
    drn = !empty && (!lr || hz);
    s.hz = hz; s.full = full; s.empty = empty; s.we = drn || byp; s.addr = la;
    exp_st.push_back(s);
    w.addr = {sa[31:2], 2'b00}; w.be = sb; w.data = sd; w.pc = sp;
    if (drn) void'(model_q.pop_front());
    acc = sr && !full && !byp;
    if (acc) begin
      model_q.push_back(w);
      exp_wr.push_back(w);
    end
    if (byp) exp_wr.push_back(w);
  endtask

  st_t mon_s;
  wr_t mon_w;
  always @(negedge clk) begin
    if (exp_st.size() > 0) begin
      mon_s = exp_st.pop_front();
      chk("ld_hazard", 32'(ld_hazard), 32'(mon_s.hz));
      chk("st_full", 32'(st_full), 32'(mon_s.full));
      chk("sb_empty", 32'(sb_empty), 32'(mon_s.empty));
      chk("ram_we", 32'(ram_we), 32'(mon_s.we));
      if (!mon_s.we && !ram_we) begin
        chk("ram_addr_load", ram_addr, mon_s.addr);
        chk("ram_idle_payload", {28'h0, ram_be} | ram_wdata | ram_pc, 32'h0);
      end
    end else begin
      chk("idle_ram_we", 32'(ram_we), 32'h0);
    end
    if (ram_we) begin
      if (exp_wr.size() > 0) begin
        mon_w = exp_wr.pop_front();
        chk("wr_addr", ram_addr, mon_w.addr);
        chk("wr_be", 32'(ram_be), 32'(mon_w.be));
        chk("wr_data", ram_wdata, mon_w.data);
        chk("wr_pc", ram_pc, mon_w.pc);
        $display("write addr=%h be=%h data=%h pc=%h", ram_addr, ram_be, ram_wdata, ram_pc);
      end else begin
        chk("unexpected_write", 32'(ram_we), 32'h0);
      end
    end
  end

  task automatic do_reset(input logic [31:0] probe_addr);
    st_req = 1'b0; ld_req = 1'b1; ld_addr = probe_addr;
    reset = 1'b0;
    #1;
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_sb_empty", 32'(sb_empty), 32'h1);
    chk("rst_st_full", 32'(st_full), 32'h0);
    chk("rst_ld_hazard", 32'(ld_hazard), 32'h0);
    chk("rst_ram_addr", ram_addr, probe_addr);
    model_q.delete(); exp_wr.delete(); exp_st.delete();
    repeat (2) @(posedge clk);
    #1;
    ld_req = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic        have_st;
    logic [31:0] sa, sd, sp, la;
    logic [3:0]  sb;
    logic        lr;
    int          pc_ctr;

    #1;
    do_reset(32'h30);

    // Fill the queue while a non-conflicting load holds the port, then hold a 5th store.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h10 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), 32'h1000 + 32'(4*i), 1'b1, 32'h24, acc);
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 32'h20, 4'hF, 32'hA4, 32'h1010, 1'b1, 32'h24, acc);
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++)
      cycle(1'b1, 32'h20, 4'hF, 32'hA4, 32'h1010, 1'b0, 32'h24, acc);
    chk("fifth_store_accepted", 32'(acc), 32'h1);
    repeat (6) cycle(1'b0, 0, 0, 0, 0, 1'b0, 32'h0, acc);

    // Hazarded sub-word load forces the matching entry out.
    cycle(1'b1, 32'h14, 4'h1, 32'hFF, 32'h2000, 1'b1, 32'h24, acc);
    repeat (3) cycle(1'b0, 0, 0, 0, 0, 1'b1, 32'h15, acc);

    // Reset in the middle of an active drain.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h10 + 32'(4*i), 4'hF, 32'hB0 + 32'(i), 32'h3000 + 32'(4*i), 1'b1, 32'h2C, acc);
    cycle(1'b0, 0, 0, 0, 0, 1'b0, 32'h0, acc);
    #2;
    do_reset(32'h14);
    repeat (3) cycle(1'b0, 0, 0, 0, 0, 1'b0, 32'h0, acc);

    // Store to an empty buffer with no load.
    cycle(1'b1, 32'h40, 4'hC, 32'hCAFE0000, 32'h4000, 1'b0, 32'h0, acc);
    repeat (2) cycle(1'b0, 0, 0, 0, 0, 1'b0, 32'h0, acc);

    have_st = 1'b0; sa = '0; sb = '0; sd = '0; sp = '0; pc_ctr = 0;
    for (int n = 0; n < 600; n++) begin
      if (!have_st && $urandom_range(0, 9) < 6) begin
        have_st = 1'b1;
        sa = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
        sb = be_tab[$urandom_range(0, 6)];
        sd = $urandom;
        sp = 32'h8000 + 32'(4 * pc_ctr);
        pc_ctr++;
      end
      lr = ($urandom_range(0, 1) == 1);
      la = 32'h100 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
      cycle(have_st, sa, sb, sd, sp, lr, la, acc);
      if (acc || (have_st && exp_wr.size() > 0 && !lr && model_q.size() == 0 && !acc))
        have_st = 1'b0;
    end

    for (int i = 0; i < 20; i++) cycle(1'b0, 0, 0, 0, 0, 1'b0, 32'h0, acc);
    @(negedge clk); #1;
    chk("model_drained", 32'(model_q.size()), 32'h0);
    chk("writes_outstanding", 32'(exp_wr.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
